// File: rtl/ioac_ins_loader.sv
// Instruction loader: buffers bytes pushed by the I/O access controller in a
// small FIFO and writes them sequentially into program memory using a
// request/acknowledge handshake. Reports remaining load capacity on IPP.
module ioac_ins_loader #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic [7:0]    InsByte,
  input  logic          GiveIns,
  input  logic          Clear,
  output logic          MemWr,
  output logic [AW-1:0] MemAddr,
  output logic [7:0]    MemData,
  input  logic          MemAck,
  output logic [3:0]    IPP,
  output logic          Full,
  output logic          Overflow,
  output logic          Busy,
  output logic [AW:0]   WrCount
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned SW0 = (AW + 1 > CW) ? AW + 1 : CW;
  localparam int unsigned SW  = (SW0 > 5) ? SW0 : 5;

  localparam logic [AW:0]   CAP     = {1'b1, {AW{1'b0}}};
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_WRITE
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW:0]     acc_q, acc_d;
  logic [AW:0]     wraddr_q, wraddr_d;
  logic            ovf_q, ovf_d;

  logic [SW-1:0]   mem_room, fifo_room, space;
  logic            push, pop;

  // Load capacity: limited by both the remaining memory and the FIFO room.
  always_comb begin
    mem_room  = SW'(CAP - acc_q);
    fifo_room = SW'(DEPTH_C - count_q);
    space     = (mem_room < fifo_room) ? mem_room : fifo_room;
    IPP       = (space > SW'(15)) ? 4'd15 : space[3:0];
    Full      = (acc_q == CAP);
  end

  // Push/pop decisions and next values of the FIFO bookkeeping registers.
  always_comb begin
    push     = GiveIns & (space != '0) & ~Clear;
    pop      = (state_q == ST_WRITE) & MemAck & ~Clear;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    acc_d    = acc_q;
    wraddr_d = wraddr_q;
    ovf_d    = ovf_q;
    if (Clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      acc_d    = '0;
      wraddr_d = '0;
      ovf_d    = 1'b0;
    end else begin
      if (GiveIns && space == '0) ovf_d = 1'b1;
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        acc_d    = acc_q + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        wraddr_d = wraddr_q + (AW+1)'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Bookkeeping registers, cleared asynchronously on Rst.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      wraddr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      wraddr_q <= wraddr_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents need no reset since reads are gated by count.
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= InsByte;
  end

  // FSM state register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: the decision uses the post-edge count so a push in IDLE
  // raises MemWr on the very next cycle, and a same-cycle push keeps WRITE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (count_d != '0) state_d = ST_WRITE;
      ST_WRITE: if (pop && count_d == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (Clear) state_d = ST_IDLE;
  end

  // FSM outputs: memory port and status.
  always_comb begin
    MemWr    = (state_q == ST_WRITE);
    MemAddr  = wraddr_q[AW-1:0];
    MemData  = MemWr ? mem_q[rd_ptr_q] : '0;
    Busy     = MemWr | (count_q != '0);
    Overflow = ovf_q;
    WrCount  = wraddr_q;
  end

endmodule

// File: tb/tb_ioac_ins_loader.sv
// Bench for ioac_ins_loader: two instances (AW=8 and AW=3) share stimulus and
// are each checked every cycle against a queue-level model, plus directed
// scenarios with literal expectations.
module tb_ioac_ins_loader;

  logic       Clk;
  logic       Rst;
  logic [7:0] InsByte;
  logic       GiveIns;
  logic       Clear;
  logic       MemAck;

  logic       MemWr0, Full0, Ovf0, Busy0;
  logic [7:0] MemAddr0, MemData0;
  logic [3:0] IPP0;
  logic [8:0] WrCount0;

  logic       MemWr1, Full1, Ovf1, Busy1;
  logic [2:0] MemAddr1;
  logic [7:0] MemData1;
  logic [3:0] IPP1;
  logic [3:0] WrCount1;

  int tests = 0;
  int fails = 0;
  bit chk_on = 0;

  ioac_ins_loader #(.AW(8), .DEPTH(4)) dut0 (
    .Clk(Clk), .Rst(Rst), .InsByte(InsByte), .GiveIns(GiveIns), .Clear(Clear),
    .MemWr(MemWr0), .MemAddr(MemAddr0), .MemData(MemData0), .MemAck(MemAck),
    .IPP(IPP0), .Full(Full0), .Overflow(Ovf0), .Busy(Busy0), .WrCount(WrCount0)
  );

  ioac_ins_loader #(.AW(3), .DEPTH(4)) dut1 (
    .Clk(Clk), .Rst(Rst), .InsByte(InsByte), .GiveIns(GiveIns), .Clear(Clear),
    .MemWr(MemWr1), .MemAddr(MemAddr1), .MemData(MemData1), .MemAck(MemAck),
    .IPP(IPP1), .Full(Full1), .Overflow(Ovf1), .Busy(Busy1), .WrCount(WrCount1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: per instance a queue of pending bytes (ring of 16),
  // bytes accepted, bytes written and the overflow flag.
  logic [7:0] mq [2][16];
  int mh [2];
  int ms [2];
  int macc [2];
  int mwr [2];
  bit movf [2];

  function automatic int mcap(input int i);
    return (i == 0) ? 256 : 8;
  endfunction

  function automatic int mspace(input int i);
    int a, b;
    a = mcap(i) - macc[i];
    b = 4 - ms[i];
    return (a < b) ? a : b;
  endfunction

  task automatic mclear(input int i);
    mh[i] = 0; ms[i] = 0; macc[i] = 0; mwr[i] = 0; movf[i] = 0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) mclear(i);
    forever begin
      @(posedge Clk or posedge Rst);
      for (int i = 0; i < 2; i++) begin
        if (Rst || Clear) mclear(i);
        else begin
          int sp;
          bit pp;
          sp = mspace(i);
          pp = (ms[i] != 0) && MemAck;
          if (GiveIns && sp == 0) movf[i] = 1;
          if (pp) begin
            mh[i] = (mh[i] + 1) % 16;
            ms[i]--;
            mwr[i]++;
          end
          if (GiveIns && sp > 0) begin
            mq[i][(mh[i] + ms[i]) % 16] = InsByte;
            ms[i]++;
            macc[i]++;
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge Clk);
      if (chk_on) begin
        int sp0, sp1;
        sp0 = mspace(0);
        sp1 = mspace(1);
        chk("d0.MemWr",   MemWr0,   ms[0] != 0);
        chk("d0.MemAddr", MemAddr0, mwr[0] % 256);
        chk("d0.MemData", MemData0, (ms[0] != 0) ? mq[0][mh[0]] : 0);
        chk("d0.IPP",     IPP0,     (sp0 > 15) ? 15 : sp0);
        chk("d0.Full",    Full0,    macc[0] == 256);
        chk("d0.Ovf",     Ovf0,     movf[0]);
        chk("d0.Busy",    Busy0,    ms[0] != 0);
        chk("d0.WrCount", WrCount0, mwr[0]);
        chk("d1.MemWr",   MemWr1,   ms[1] != 0);
        chk("d1.MemAddr", MemAddr1, mwr[1] % 8);
        chk("d1.MemData", MemData1, (ms[1] != 0) ? mq[1][mh[1]] : 0);
        chk("d1.IPP",     IPP1,     (sp1 > 15) ? 15 : sp1);
        chk("d1.Full",    Full1,    macc[1] == 8);
        chk("d1.Ovf",     Ovf1,     movf[1]);
        chk("d1.Busy",    Busy1,    ms[1] != 0);
        chk("d1.WrCount", WrCount1, mwr[1]);
      end
    end
  end

  // Drive one cycle of inputs, then sample #1 after the edge.
  task automatic cyc(input bit g, input logic [7:0] b, input bit a, input bit c);
    GiveIns = g;
    InsByte = b;
    MemAck  = a;
    Clear   = c;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1;
    GiveIns = 0; InsByte = 0; MemAck = 0; Clear = 0;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int pg, pa;
    Rst = 1'b1;
    GiveIns = 0; InsByte = 0; MemAck = 0; Clear = 0;
    #12;
    chk_on = 1;
    chk("rst.MemWr",   MemWr0,   0);
    chk("rst.Busy",    Busy0,    0);
    chk("rst.IPP",     IPP0,     4);
    chk("rst.WrCount", WrCount0, 0);
    chk("rst.IPP1",    IPP1,     4);
    @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk);
    #1;

    // Single byte, immediate ack.
    cyc(1, 8'h18, 0, 0);
    chk("s1.MemWr",   MemWr0,   1);
    chk("s1.MemAddr", MemAddr0, 0);
    chk("s1.MemData", MemData0, 8'h18);
    cyc(0, 8'h00, 1, 0);
    chk("s1.WrCount", WrCount0, 1);
    chk("s1.Busy",    Busy0,    0);

    // Three pushes with ack withheld, then drained one per cycle.
    do_reset();
    cyc(1, 8'h4D, 0, 0); chk("s2.IPP_a", IPP0, 3);
    cyc(1, 8'h12, 0, 0); chk("s2.IPP_b", IPP0, 2);
    cyc(1, 8'h34, 0, 0); chk("s2.IPP_c", IPP0, 1);
    chk("s2.addr0", MemAddr0, 0); chk("s2.data0", MemData0, 8'h4D);
    cyc(0, 8'h00, 1, 0);
    chk("s2.addr1", MemAddr0, 1); chk("s2.data1", MemData0, 8'h12);
    cyc(0, 8'h00, 1, 0);
    chk("s2.addr2", MemAddr0, 2); chk("s2.data2", MemData0, 8'h34);
    cyc(0, 8'h00, 1, 0);
    chk("s2.MemWr", MemWr0, 0);
    chk("s2.IPP",   IPP0,   4);
    chk("s2.WrCnt", WrCount0, 3);

    // AW=3 instance: fill memory with push/ack overlapping every cycle.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cyc(1, 8'(8'h10 + k), 1, 0);
      chk("s3.MemWr1",   MemWr1,   1);
      chk("s3.MemData1", MemData1, 8'h10 + k);
    end
    cyc(0, 8'h00, 1, 0);
    chk("s3.Full1",  Full1,    1);
    chk("s3.IPP1",   IPP1,     0);
    chk("s3.WrCnt1", WrCount1, 8);
    cyc(1, 8'h99, 1, 0);
    chk("s3.Ovf1",   Ovf1,     1);
    chk("s3.MemWr1", MemWr1,   0);
    chk("s3.WrCnt1b", WrCount1, 8);
    chk("s3.Ovf0",   Ovf0,     0);
    cyc(0, 8'h00, 0, 0);

    // Clear with a write in flight and an ack in the same cycle.
    do_reset();
    for (int k = 0; k < 5; k++) cyc(1, 8'(8'h20 + k), 1, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(1, 8'hA1, 0, 0);
    cyc(1, 8'hA2, 0, 0);
    chk("s4.MemAddr", MemAddr0, 5);
    chk("s4.MemWr",   MemWr0,   1);
    cyc(0, 8'h00, 1, 1);
    chk("s4.WrCount", WrCount0, 0);
    chk("s4.MemWr",   MemWr0,   0);
    chk("s4.Ovf",     Ovf0,     0);
    chk("s4.IPP",     IPP0,     4);
    cyc(1, 8'h5A, 0, 0);
    chk("s4.addr",    MemAddr0, 0);
    chk("s4.data",    MemData0, 8'h5A);

    // Asynchronous reset while a write is pending.
    GiveIns = 0; MemAck = 0; Clear = 0;
    #3;
    Rst = 1'b1;
    #1;
    chk("s5.MemWr",   MemWr0,   0);
    chk("s5.MemWr1",  MemWr1,   0);
    chk("s5.Busy",    Busy0,    0);
    chk("s5.MemData", MemData0, 0);
    chk("s5.IPP",     IPP0,     4);
    chk("s5.WrCount", WrCount0, 0);
    @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk);
    #1;

    // Random traffic with varying push/ack densities and rare Clear.
    for (int blk = 0; blk < 30; blk++) begin
      pg = $urandom_range(20, 90);
      pa = $urandom_range(10, 100);
      for (int n = 0; n < 100; n++) begin
        cyc($urandom_range(0, 99) < pg, 8'($urandom), $urandom_range(0, 99) < pa,
            $urandom_range(0, 79) == 0);
      end
    end
    cyc(0, 8'h00, 0, 0);
    @(negedge Clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ioac_ins_loader.md
# ioac_ins_loader

- Sits directly downstream of the I/O access controller.
- Accepts the instruction bytes that the controller emits on `GiveIns` strobes, buffers them in a small FIFO and writes them sequentially into program memory through a request/acknowledge port.
- Reports remaining load capacity back to the controller on `IPP`. The controller checks `IPP` before issuing a 1-, 2- or 3-byte instruction.

## Interface
Parameters:
- AW, 8, program-memory address width; capacity 2^AW bytes.
- DEPTH, 4, FIFO depth; power of two, ≥4.

Ports:
- Clk  in  1  clock; all state on rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- InsByte  in  8  instruction byte from controller; valid when GiveIns=1.
- GiveIns  in  1  one-cycle push strobe.
- Clear  in  1  synchronous restart: empty FIFO, load address back to 0.
- MemWr  out  1  write request to program memory.
- MemAddr  out  AW  write address.
- MemData  out  8  write data.
- MemAck  in  1  write accepted; sampled only while MemWr=1.
- IPP  out  4  bytes the controller may still push, saturated at 15.
- Full  out  1  all 2^AW bytes accepted.
- Overflow  out  1  sticky; push attempted while no space.
- Busy  out  1  FIFO non-empty or write pending.
- WrCount  out  AW+1  bytes committed to memory.

## Operation
- Registers:
  - FIFO with rd/wr pointers and count (0..DEPTH).
  - AccCnt (AW+1 bits): bytes accepted since reset/Clear, 0..2^AW.
  - WrAddr (AW+1 bits): next write address; equals WrCount.
  - FSM state.
  - Overflow flag.
- Space = min(2^AW − AccCnt, DEPTH − count). IPP = min(Space, 15). Full = (AccCnt == 2^AW).
- Push: GiveIns=1 and Space>0 → byte enters FIFO tail, AccCnt+1.
- GiveIns=1 with Space=0 → byte dropped, Overflow←1, no other state change.
- FSM:
  - IDLE: MemWr=0. If count>0 at the clock edge → WRITE.
  - WRITE: MemWr=1, MemAddr=WrAddr[AW-1:0], MemData=FIFO head; both are held stable until MemAck.
  - WRITE with MemAck=1: pop head, WrAddr+1. If FIFO is still non-empty after the pop (counting a same-cycle push) → stay in WRITE with the next head; else → IDLE.
- MemAck is ignored in IDLE.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Clear (priority over GiveIns and MemAck in the same cycle):
  - Resets count, pointers, AccCnt, WrAddr and Overflow to 0, and the FSM to IDLE.
  - A write in flight is abandoned: MemWr drops the next cycle, and a late MemAck is ignored.
- MemData is 0 and MemAddr is WrAddr whenever MemWr=0.
- Busy = (state==WRITE) | (count≠0).

## Timing
- Reset values:
  - MemWr=0, MemAddr=0, MemData=0, Full=0, Overflow=0, Busy=0, WrCount=0, FSM=IDLE.
  - IPP=min(2^AW, DEPTH, 15), which is 4 with default parameters.
- IPP, Full and Space are combinational from registered state. They reflect a push from the cycle after the GiveIns edge, so the controller sees updated IPP before its next LoadIns.
- Latency: byte pushed at edge N → MemWr=1 with that byte from cycle N+1 (FIFO was empty and FSM in IDLE).
- MemAck may be asserted in the same cycle MemWr rises. Sustained throughput is 1 byte/cycle with a zero-wait memory.
- Three back-to-back GiveIns pulses, with IPP≥3 beforehand, are always accepted regardless of memory wait states (DEPTH≥4).
- WrCount updates at the MemAck edge.
- Full stays 1 until Clear or Rst.
- Rst mid-write: MemWr drops immediately (async) and all state clears.

## Test plan
- Reset → MemWr=0, Busy=0, IPP=4, WrCount=0. Deassert Rst, push 0x18 → next cycle MemWr=1, MemAddr=0, MemData=0x18. MemAck same cycle → WrCount=1, Busy=0 one cycle later.
- Three consecutive GiveIns (0x4D, 0x12, 0x34) with MemAck held off 3 cycles → IPP reads 3, 2, 1 after successive pushes. Then MemAck every cycle → addresses 0, 1, 2 written in order with unchanged data; IPP returns to 4.
- AW=3: push 8 bytes with immediate ack → Full=1, IPP=0, WrCount=8. A ninth GiveIns → Overflow=1, no MemWr, WrCount stays 8.
- Push at the same edge as MemAck for the head byte → count unchanged, data order preserved, MemWr stays high continuously.
- Two bytes pending, MemWr=1 at MemAddr=5, Clear pulsed with MemAck=1 the same cycle → WrCount=0, MemWr=0 next cycle, Overflow=0, IPP=4. The next push writes to address 0.
- Rst asserted asynchronously mid-WRITE → MemWr falls without waiting for Clk; all outputs at reset values.
